// File: rtl/anti_theft_controller.sv
// rtl/anti_theft_controller.sv - multi-door anti-theft FSM with countdown, timed siren and door latch
// Single registered FSM; siren decodes straight from the state register.
module anti_theft_controller #(
  parameter int NUM_DOORS    = 4,
  parameter int TIME_W       = 4,
  parameter int T_ARM_DEF    = 6,
  parameter int T_DRIVER_DEF = 8,
  parameter int T_PASS_DEF   = 15,
  parameter int T_ALARM_DEF  = 10,
  parameter int BLINK_TICKS  = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 tick_1hz,
  input  logic                 ignition,
  input  logic [NUM_DOORS-1:0] doors,
  input  logic                 reprogram,
  input  logic [1:0]           prog_sel,
  input  logic [TIME_W-1:0]    prog_value,
  output logic                 status,
  output logic                 siren,
  output logic [2:0]           state,
  output logic [TIME_W-1:0]    time_left,
  output logic [NUM_DOORS-1:0] door_latched
);

  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  typedef enum logic [2:0] {
    ARMED      = 3'd0,
    TRIGGERED  = 3'd1,
    SOUNDING   = 3'd2,
    DISARMED   = 3'd3,
    WAIT_OPEN  = 3'd4,
    WAIT_CLOSE = 3'd5,
    ARM_DELAY  = 3'd6
  } state_t;

  state_t               st;
  logic [TIME_W-1:0]    t_arm, t_drv, t_pass, t_alarm;
  logic [BW-1:0]        blink_cnt;
  logic [NUM_DOORS-1:0] doors_q;
  logic [NUM_DOORS-1:0] door_rise;
  logic                 expired;

  assign state     = st;
  assign siren     = (st == SOUNDING);
  assign expired   = (time_left == '0);
  assign door_rise = doors & ~doors_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st           <= ARMED;
      time_left    <= '0;
      status       <= 1'b0;
      door_latched <= '0;
      blink_cnt    <= '0;
      doors_q      <= '0;
      t_arm        <= TIME_W'(T_ARM_DEF);
      t_drv        <= TIME_W'(T_DRIVER_DEF);
      t_pass       <= TIME_W'(T_PASS_DEF);
      t_alarm      <= TIME_W'(T_ALARM_DEF);
    end else begin
      doors_q <= doors;
      if (reprogram) begin
        case (prog_sel)
          2'd0:    t_arm   <= prog_value;
          2'd1:    t_drv   <= prog_value;
          2'd2:    t_pass  <= prog_value;
          default: t_alarm <= prog_value;
        endcase
        st           <= ARMED;
        time_left    <= '0;
        status       <= 1'b0;
        door_latched <= '0;
        blink_cnt    <= '0;
      end else begin
        case (st)
          ARMED: begin
            if (doors != '0) begin
              st           <= TRIGGERED;
              time_left    <= doors[0] ? t_drv : t_pass;
              door_latched <= doors;
              status       <= 1'b1;
            end else if (ignition) begin
              st     <= DISARMED;
              status <= 1'b0;
            end else if (tick_1hz) begin
              // status flips once every BLINK_TICKS ticks spent in ARMED
              if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
                blink_cnt <= '0;
                status    <= ~status;
              end else begin
                blink_cnt <= blink_cnt + 1'b1;
              end
            end
          end
          TRIGGERED: begin
            if (expired) begin
              st        <= SOUNDING;
              time_left <= t_alarm;
            end else if (ignition) begin
              st           <= DISARMED;
              time_left    <= '0;
              status       <= 1'b0;
              door_latched <= '0;
            end else if (tick_1hz) begin
              time_left <= time_left - 1'b1;
            end
          end
          SOUNDING: begin
            if (ignition) begin
              st        <= DISARMED;
              time_left <= '0;
              status    <= 1'b0;
            end else if (expired && doors == '0) begin
              st        <= ARMED;
              status    <= 1'b0;
              blink_cnt <= '0;
            end else if (expired) begin
              time_left <= t_alarm;
            end else if (door_rise != '0) begin
              time_left    <= t_alarm;
              door_latched <= door_latched | door_rise;
            end else if (tick_1hz) begin
              time_left <= time_left - 1'b1;
            end
          end
          DISARMED: begin
            if (!ignition) st <= WAIT_OPEN;
          end
          WAIT_OPEN: begin
            if (ignition)      st <= DISARMED;
            else if (doors[0]) st <= WAIT_CLOSE;
          end
          WAIT_CLOSE: begin
            if (ignition) begin
              st <= DISARMED;
            end else if (!doors[0]) begin
              st        <= ARM_DELAY;
              time_left <= t_arm;
            end
          end
          ARM_DELAY: begin
            if (ignition) begin
              st        <= DISARMED;
              time_left <= '0;
            end else if (doors[0]) begin
              st        <= WAIT_CLOSE;
              time_left <= '0;
            end else if (expired) begin
              st        <= ARMED;
              status    <= 1'b0;
              blink_cnt <= '0;
            end else if (tick_1hz) begin
              time_left <= time_left - 1'b1;
            end
          end
          default: begin
            st        <= ARMED;
            time_left <= '0;
            status    <= 1'b0;
            blink_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_anti_theft_controller.sv
// tb/tb_anti_theft_controller.sv - directed table, corner sequences and random run against a reference model
module tb_anti_theft_controller;

  localparam int ND = 4;
  localparam int TW = 4;
  localparam int BLINK = 2;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          tick_1hz = 1'b0;
  logic          ignition = 1'b0;
  logic [ND-1:0] doors = '0;
  logic          reprogram = 1'b0;
  logic [1:0]    prog_sel = '0;
  logic [TW-1:0] prog_value = '0;
  logic          status, siren;
  logic [2:0]    state;
  logic [TW-1:0] time_left;
  logic [ND-1:0] door_latched;

  anti_theft_controller dut (
    .clock(clock), .reset_n(reset_n), .tick_1hz(tick_1hz), .ignition(ignition),
    .doors(doors), .reprogram(reprogram), .prog_sel(prog_sel), .prog_value(prog_value),
    .status(status), .siren(siren), .state(state), .time_left(time_left),
    .door_latched(door_latched)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: mode codes, seconds remaining, ticks counted since entering ARMED.
  localparam int M_ARMED = 0, M_TRIG = 1, M_SOUND = 2, M_DIS = 3, M_WOPEN = 4, M_WCLOSE = 5, M_ADEL = 6;
  int      m_mode, m_left, m_armed_ticks;
  int      m_delay[4];
  bit [3:0] m_latched, m_prev;

  function automatic void model_reset();
    m_mode = M_ARMED; m_left = 0; m_armed_ticks = 0;
    m_delay[0] = 6; m_delay[1] = 8; m_delay[2] = 15; m_delay[3] = 10;
    m_latched = '0; m_prev = '0;
  endfunction

  function automatic void model_step(bit tk, bit ig, bit [3:0] dr, bit rp, int sel, int val);
    bit       done;
    bit [3:0] rise;
    done = (m_left == 0);
    rise = dr & ~m_prev;
    if (rp) begin
      m_delay[sel] = val; m_mode = M_ARMED; m_left = 0; m_latched = '0; m_armed_ticks = 0;
    end else begin
      case (m_mode)
        M_ARMED:
          if (dr != 0) begin
            m_mode = M_TRIG; m_left = dr[0] ? m_delay[1] : m_delay[2]; m_latched = dr;
          end else if (ig) m_mode = M_DIS;
          else if (tk) m_armed_ticks++;
        M_TRIG:
          if (done) begin m_mode = M_SOUND; m_left = m_delay[3]; end
          else if (ig) begin m_mode = M_DIS; m_left = 0; m_latched = '0; end
          else if (tk) m_left--;
        M_SOUND:
          if (ig) begin m_mode = M_DIS; m_left = 0; end
          else if (done && dr == 0) begin m_mode = M_ARMED; m_armed_ticks = 0; end
          else if (done) m_left = m_delay[3];
          else if (rise != 0) begin m_left = m_delay[3]; m_latched |= rise; end
          else if (tk) m_left--;
        M_DIS: if (!ig) m_mode = M_WOPEN;
        M_WOPEN:
          if (ig) m_mode = M_DIS;
          else if (dr[0]) m_mode = M_WCLOSE;
        M_WCLOSE:
          if (ig) m_mode = M_DIS;
          else if (!dr[0]) begin m_mode = M_ADEL; m_left = m_delay[0]; end
        default:
          if (ig) begin m_mode = M_DIS; m_left = 0; end
          else if (dr[0]) begin m_mode = M_WCLOSE; m_left = 0; end
          else if (done) begin m_mode = M_ARMED; m_armed_ticks = 0; end
          else if (tk) m_left--;
      endcase
    end
    m_prev = dr;
  endfunction

  function automatic int model_status();
    if (m_mode == M_TRIG || m_mode == M_SOUND) return 1;
    if (m_mode == M_ARMED) return (m_armed_ticks / BLINK) % 2;
    return 0;
  endfunction

  task automatic step(input bit tk, input bit ig, input bit [3:0] dr,
                      input bit rp = 0, input int sel = 0, input int val = 0);
    @(negedge clock);
    tick_1hz = tk; ignition = ig; doors = dr; reprogram = rp;
    prog_sel = 2'(sel); prog_value = TW'(val);
    model_step(tk, ig, dr, rp, sel, val);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0; tick_1hz = 0; ignition = 0; doors = '0; reprogram = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic check_outs(input string tag, input int st, input int tl, input int stat, input int lat);
    check({tag, " state"}, int'(state), st);
    check({tag, " time_left"}, int'(time_left), tl);
    check({tag, " status"}, int'(status), stat);
    check({tag, " siren"}, int'(siren), (st == 2) ? 1 : 0);
    check({tag, " door_latched"}, int'(door_latched), lat);
  endtask

  typedef struct {
    bit       tk;
    bit       ig;
    bit [3:0] dr;
    int       st;
    int       tl;
    int       stat;
    int       lat;
  } vec_t;

  vec_t vecs[20];

  initial begin
    // driver trigger, disarm mid-count, exit path with aborted arm delay, blink
    vecs[0]  = '{0, 0, 4'b0001, 1, 8, 1, 1};
    vecs[1]  = '{1, 0, 4'b0000, 1, 7, 1, 1};
    vecs[2]  = '{1, 1, 4'b0000, 3, 0, 0, 0};
    vecs[3]  = '{0, 0, 4'b0000, 4, 0, 0, 0};
    vecs[4]  = '{0, 0, 4'b0001, 5, 0, 0, 0};
    vecs[5]  = '{0, 0, 4'b0000, 6, 6, 0, 0};
    vecs[6]  = '{1, 0, 4'b0000, 6, 5, 0, 0};
    vecs[7]  = '{0, 0, 4'b0001, 5, 0, 0, 0};
    vecs[8]  = '{0, 0, 4'b0000, 6, 6, 0, 0};
    for (int i = 0; i < 6; i++) vecs[9 + i] = '{1, 0, 4'b0000, 6, 5 - i, 0, 0};
    vecs[15] = '{0, 0, 4'b0000, 0, 0, 0, 0};
    vecs[16] = '{1, 0, 4'b0000, 0, 0, 0, 0};
    vecs[17] = '{1, 0, 4'b0000, 0, 0, 1, 0};
    vecs[18] = '{1, 0, 4'b0000, 0, 0, 1, 0};
    vecs[19] = '{1, 0, 4'b0000, 0, 0, 0, 0};

    do_reset();
    #1;
    check_outs("reset", 0, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].tk, vecs[i].ig, vecs[i].dr);
      check_outs($sformatf("vec%0d", i), vecs[i].st, vecs[i].tl, vecs[i].stat, vecs[i].lat);
    end

    // driver countdown to siren, re-trigger by rising edge, reload with a door held open
    step(0, 0, 4'b0001);
    repeat (8) step(1, 0, 4'b0000);
    check_outs("drv_expired", 1, 0, 1, 1);
    step(0, 0, 4'b0000);
    check_outs("siren_on", 2, 10, 1, 1);
    repeat (4) step(1, 0, 4'b0000);
    check("sound_tick4 time_left", int'(time_left), 6);
    step(0, 0, 4'b1000);
    check_outs("rise_reload", 2, 10, 1, 4'b1001);
    repeat (10) step(1, 0, 4'b1000);
    step(0, 0, 4'b1000);
    check_outs("held_reload", 2, 10, 1, 4'b1001);
    repeat (10) step(1, 0, 4'b0000);
    step(0, 0, 4'b0000);
    check_outs("siren_done", 0, 0, 0, 4'b1001);

    // reprogram during SOUNDING, then a zero driver delay
    step(0, 0, 4'b0001);
    repeat (8) step(1, 0, 4'b0000);
    step(0, 0, 4'b0000);
    check("pre_rp state", int'(state), 2);
    step(0, 0, 4'b0000, 1, 1, 3);
    check_outs("rp_sound", 0, 0, 0, 0);
    step(0, 0, 4'b0001);
    check_outs("drv3", 1, 3, 1, 1);
    step(0, 0, 4'b0000, 1, 1, 0);
    step(0, 0, 4'b0001);
    check_outs("drv0", 1, 0, 1, 1);
    step(0, 0, 4'b0000);
    check_outs("drv0_sound", 2, 10, 1, 1);

    // asynchronous reset between edges, delays back to defaults
    step(0, 0, 4'b0000, 1, 2, 5);
    step(0, 0, 4'b0100);
    check_outs("pass5", 1, 5, 1, 4'b0100);
    #2 reset_n = 1'b0;
    #1;
    check_outs("async_rst", 0, 0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    step(0, 0, 4'b0100);
    check_outs("pass_default", 1, 15, 1, 4'b0100);

    // random run against the model
    do_reset();
    begin
      bit       ig_r = 0;
      bit [3:0] dr_r = '0;
      for (int c = 0; c < 3000; c++) begin
        bit rp_r;
        if ($urandom_range(0, 15) == 0) ig_r = ~ig_r;
        for (int b = 0; b < 4; b++)
          if ($urandom_range(0, 11) == 0) dr_r[b] = ~dr_r[b];
        rp_r = ($urandom_range(0, 59) == 0);
        step(1'($urandom_range(0, 1)), ig_r, dr_r, rp_r, int'($urandom_range(0, 3)),
             int'($urandom_range(0, 15)));
        check_outs($sformatf("rnd%0d", c), m_mode, m_left, model_status(), int'(m_latched));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
